// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranger controller: periodic trigger pulse, echo-width measurement
// in whole centimetres with saturation at 511 cm, and no-echo timeout reporting.
module ultrasonic_ranger #(
   parameter int unsigned TRIG_CYCLES      = 500,
   parameter int unsigned CYCLES_PER_CM    = 2900,
   parameter int unsigned ECHO_WAIT_CYCLES = 1500000,
   parameter int unsigned PERIOD_CYCLES    = 3000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       echo,
   output logic       trigger,
   output logic [8:0] distance,
   output logic       distance_valid,
   output logic       timeout,
   output logic       busy
);

   localparam int unsigned DIST_W    = 9;
   localparam int unsigned TIMER_MAX = (TRIG_CYCLES > ECHO_WAIT_CYCLES) ? TRIG_CYCLES : ECHO_WAIT_CYCLES;
   localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
   localparam int unsigned SUB_W     = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
   localparam int unsigned PERIOD_W  = $clog2(PERIOD_CYCLES + 1);

   localparam logic [DIST_W-1:0]   DIST_MAX     = '1;
   localparam logic [DIST_W-1:0]   DIST_PRE_MAX = DIST_MAX - DIST_W'(1);
   localparam logic [PERIOD_W-1:0] PERIOD_MAX   = '1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TRIG      = 3'd1,
      ST_WAIT_ECHO = 3'd2,
      ST_MEASURE   = 3'd3,
      ST_HOLDOFF   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [SUB_W-1:0]    sub_q, sub_d;
   logic [DIST_W-1:0]   cm_q, cm_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                echo_meta_q, echo_meta_d;
   logic                echo_s_q, echo_s_d;
   logic                trigger_q, trigger_d;
   logic [DIST_W-1:0]   distance_q, distance_d;
   logic                distance_valid_q, distance_valid_d;
   logic                timeout_q, timeout_d;
   logic                busy_q, busy_d;

   // Echo-count step shared by the echo-detect cycle and MEASURE
   logic [SUB_W-1:0]    sub_base, sub_step;
   logic [DIST_W-1:0]   cm_base, cm_step;
   logic                sub_wrap;

   // State register, counters, synchroniser and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         timer_q          <= '0;
         sub_q            <= '0;
         cm_q             <= '0;
         period_q         <= '0;
         echo_meta_q      <= 1'b0;
         echo_s_q         <= 1'b0;
         trigger_q        <= 1'b0;
         distance_q       <= '0;
         distance_valid_q <= 1'b0;
         timeout_q        <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         timer_q          <= timer_d;
         sub_q            <= sub_d;
         cm_q             <= cm_d;
         period_q         <= period_d;
         echo_meta_q      <= echo_meta_d;
         echo_s_q         <= echo_s_d;
         trigger_q        <= trigger_d;
         distance_q       <= distance_d;
         distance_valid_q <= distance_valid_d;
         timeout_q        <= timeout_d;
         busy_q           <= busy_d;
      end
   end

   // Next-state, counter and output logic
   always_comb begin
      state_d          = state_q;
      timer_d          = timer_q;
      sub_d            = sub_q;
      cm_d             = cm_q;
      period_d         = (period_q == PERIOD_MAX) ? period_q : period_q + PERIOD_W'(1);
      echo_meta_d      = echo;
      echo_s_d         = echo_meta_q;
      distance_d       = distance_q;
      distance_valid_d = 1'b0;
      timeout_d        = timeout_q;

      // The echo-detect cycle counts as the first echo cycle from cleared counters
      sub_base = (state_q == ST_MEASURE) ? sub_q : '0;
      cm_base  = (state_q == ST_MEASURE) ? cm_q  : '0;
      sub_wrap = (sub_base == SUB_W'(CYCLES_PER_CM - 1));
      sub_step = sub_wrap ? '0 : sub_base + SUB_W'(1);
      cm_step  = sub_wrap ? cm_base + DIST_W'(1) : cm_base;

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d  = ST_TRIG;
               period_d = '0;
               timer_d  = '0;
            end
         end

         ST_TRIG: begin
            if (timer_q == TIMER_W'(TRIG_CYCLES - 1)) begin
               state_d = ST_WAIT_ECHO;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end

         ST_WAIT_ECHO: begin
            if (echo_s_q) begin
               state_d = ST_MEASURE;
               sub_d   = sub_step;
               cm_d    = cm_step;
            end else if (timer_q == TIMER_W'(ECHO_WAIT_CYCLES - 1)) begin
               state_d   = ST_HOLDOFF;
               timeout_d = 1'b1;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end

         ST_MEASURE: begin
            if (!echo_s_q) begin
               state_d          = ST_HOLDOFF;
               distance_d       = cm_q;
               distance_valid_d = 1'b1;
               timeout_d        = 1'b0;
            end else if (sub_wrap && (cm_q == DIST_PRE_MAX)) begin
               state_d          = ST_HOLDOFF;
               distance_d       = DIST_MAX;
               distance_valid_d = 1'b1;
               timeout_d        = 1'b0;
            end else begin
               sub_d = sub_step;
               cm_d  = cm_step;
            end
         end

         ST_HOLDOFF: begin
            // Overdue period (long echo) leaves as soon as echo drops
            if (!echo_s_q && (period_q >= PERIOD_W'(PERIOD_CYCLES - 2))) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      trigger_d = (state_d == ST_TRIG);
      busy_d    = (state_d != ST_IDLE);
   end

   assign trigger        = trigger_q;
   assign distance       = distance_q;
   assign distance_valid = distance_valid_q;
   assign timeout        = timeout_q;
   assign busy           = busy_q;

endmodule

// File: doc/ultrasonic_ranger.md
ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 500, trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-002 SHALL have parameter CYCLES_PER_CM, default 2900, clk cycles per centimetre of echo width (58 us at 50 MHz).
REQ-003 SHALL have parameter ECHO_WAIT_CYCLES, default 1500000, maximum wait for echo rising edge (30 ms).
REQ-004 SHALL have parameter PERIOD_CYCLES, default 3000000, trigger-to-trigger period (60 ms); must exceed TRIG_CYCLES+ECHO_WAIT_CYCLES.
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port enable  input  1  level; high = run periodic measurements.
REQ-008 SHALL have port echo  input  1  asynchronous sensor echo pulse.
REQ-009 SHALL have port trigger  output  1  sensor trigger pulse, registered.
REQ-010 SHALL have port distance  output  9  last measured distance in cm, unsigned; feeds the distance input PIO.
REQ-011 SHALL have port distance_valid  output  1  one-cycle strobe when distance is updated.
REQ-012 SHALL have port timeout  output  1  high when last measurement got no echo.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL synchronise echo through two flip-flops (echo_s); all echo decisions use echo_s only.
REQ-015 SHALL implement states IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF.
REQ-016 IDLE: if enable=1, SHALL go to TRIG next cycle and clear period counter; else stay.
REQ-017 TRIG: trigger SHALL be 1 for exactly TRIG_CYCLES consecutive cycles, then state WAIT_ECHO with trigger 0.
REQ-018 WAIT_ECHO: on echo_s=1, SHALL enter MEASURE with cm counter and sub-cycle counter cleared.
REQ-019 WAIT_ECHO: after ECHO_WAIT_CYCLES cycles without echo_s=1, SHALL set timeout=1, leave distance unchanged, no distance_valid, go HOLDOFF.
REQ-020 MEASURE: sub-cycle counter SHALL count 0..CYCLES_PER_CM-1 and wrap; each wrap increments cm counter.
REQ-021 MEASURE: on echo_s=0, SHALL load distance with cm counter (partial cm truncated), pulse distance_valid one cycle, clear timeout, go HOLDOFF.
REQ-022 MEASURE: when cm counter reaches 511 with echo_s still 1, SHALL load distance=511, pulse distance_valid, clear timeout, go HOLDOFF (saturation, no 9-bit wrap).
REQ-023 Period counter SHALL start at 0 on the first TRIG cycle and increment every cycle until next TRIG.
REQ-024 HOLDOFF: SHALL go IDLE when period counter = PERIOD_CYCLES-2 (next TRIG rising edge exactly PERIOD_CYCLES after previous) and echo_s=0; if echo_s=1, stay until echo_s=0.
REQ-025 enable deassertion SHALL only be sampled in IDLE; an in-progress measurement always completes.
REQ-026 distance and timeout SHALL hold value between updates; distance_valid and timeout never both asserted from the same measurement.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state IDLE, all counters and synchroniser flops 0, trigger=0, distance=0, distance_valid=0, timeout=0, busy=0.
REQ-028 Reset mid-measurement SHALL abort immediately with no distance_valid; after release, operation restarts from IDLE.

Verification (bench params TRIG_CYCLES=5, CYCLES_PER_CM=10, ECHO_WAIT_CYCLES=100, PERIOD_CYCLES=400)
REQ-029 Assert reset_n=0 with echo toggling -> all outputs 0; release with enable=1 -> trigger high exactly 5 cycles.
REQ-030 Echo high 123 cycles after trigger -> distance=12, distance_valid high exactly 1 cycle, timeout=0.
REQ-031 No echo -> timeout=1 about 100 cycles after trigger falls, no distance_valid, distance keeps prior value 12.
REQ-032 Echo stuck high -> distance=511 with one distance_valid after 5110 counted cycles; next trigger only after echo released.
REQ-033 enable held high, echo 50 cycles each time -> trigger rising edges exactly 400 cycles apart, distance=5 each time.
REQ-034 enable dropped during MEASURE -> measurement completes with distance_valid, FSM returns IDLE, busy=0, no further trigger.
